cmos_16_8bit_tx: RTL
====================

Name: cmos_16_8bit_tx

Overview:
- DVP-style byte-stream transmitter: the counterpart of the camera-side 8→16 receiver.
- Accepts 16-bit RGB565 pixels over a valid/ready handshake and serializes each one into two bytes, high byte first.
- Generates vsync and href (de) frame timing, so a byte-stream sink or loopback receiver sees camera-like frames.
- Used for camera emulation, loopback test and board-to-board pixel links.

Parameters:
- H_ACTIVE, 640, pixels per line; each line carries 2*H_ACTIVE byte cycles with de_o high.
- H_BLANK, 144, pclk cycles per line with de_o low, placed after the active bytes.
- V_SYNC, 3, lines with vs_o high at frame start.
- V_BACK, 17, blank lines after vsync, before the first active line.
- V_ACTIVE, 480, active lines per frame.
- V_FRONT, 10, blank lines after the last active line.

Ports:
- pclk, input, 1, byte clock; all logic is on its rising edge.
- rst, input, 1, asynchronous active-high reset.
- enable, input, 1, level; frames run while it is high.
- pix_data, input, 16, RGB565 pixel; transmitted as {high byte, low byte}.
- pix_valid, input, 1, pix_data is valid.
- pix_ready, output, 1, the block takes a pixel this cycle.
- vs_o, output, 1, vertical sync, active high.
- de_o, output, 1, href / byte-valid.
- pdata_o, output, 8, byte data.
- frame_start, output, 1, one-cycle pulse on the first vs_o cycle of each frame.
- underrun, output, 1, sticky flag; set when a pixel is not available in time.

Behaviour:
- Reset (asynchronous, active high):
  - State goes to IDLE and all counters clear.
  - vs_o, de_o, pdata_o, pix_ready, frame_start and underrun all go to 0.
  - Reset applied mid-frame aborts the frame immediately; no partial line completes.
- Line length: L = 2*H_ACTIVE + H_BLANK cycles.
- Counters:
  - hcnt counts 0..L-1 in every non-IDLE state.
  - vcnt counts the lines within the current state.
- States:
  - IDLE: all outputs low. Moves to VSYNC on the first cycle enable=1.
  - VSYNC: vs_o=1 for V_SYNC*L cycles. frame_start=1 on its first cycle only.
  - VBACK: V_BACK*L cycles with vs_o=0 and de_o=0.
  - ACTIVE: V_ACTIVE lines.
    - On each line, de_o=1 for hcnt 0..2*H_ACTIVE-1 and de_o=0 for the remaining H_BLANK cycles.
  - VFRONT: V_FRONT*L cycles with vs_o=0 and de_o=0.
    - At its end, go to VSYNC if enable=1, otherwise to IDLE.
- Any parameter set to 0 skips its state with zero cycles.
- A change of enable during a frame has no effect until the frame completes; frames are never truncated by enable.
- All outputs are registered. A state's first output cycle is the cycle after the transition edge.
- Byte phase:
  - pix_ready is combinational: high on ACTIVE cycles where the next output cycle is an even-numbered byte of the line (high-byte slot).
  - Within a line, pix_ready is asserted exactly H_ACTIVE times.
  - On an edge with pix_ready=1 and pix_valid=1:
    - pdata_o <= pix_data[15:8];
    - pix_data[7:0] is held internally;
    - on the next edge, pdata_o <= the held low byte.
    - Latency is 1 cycle from acceptance to the high byte on pdata_o; the low byte follows on the next cycle.
  - On an edge with pix_ready=1 and pix_valid=0 (underrun):
    - pdata_o <= 0x00 for both bytes of that slot; de_o still goes high (timing is rigid);
    - underrun <= 1 and stays set until reset.
    - No pixel is consumed for that slot.
- pix_ready is 0 outside ACTIVE byte slots. pix_valid is ignored there; upstream holds its data.
- pdata_o is 0x00 whenever de_o=0.
- vs_o and de_o are never high together. de_o only rises at the start of a line.
- Frame length: (V_SYNC+V_BACK+V_ACTIVE+V_FRONT)*L cycles. Back-to-back frames have no gap cycles.

Test Plan:
All scenarios use H_ACTIVE=4, H_BLANK=6, V_SYNC=2, V_BACK=1, V_ACTIVE=3, V_FRONT=1, so L=14 and a frame is 98 cycles.
1. Hold enable=1, with pix_valid=1 constantly supplying 0x1234, 0xABCD, …
   → vs_o is high for 28 cycles, then 14 low cycles, then de_o is high for 8 cycles per line.
   → Bytes appear as 12,34,AB,CD,…; frame_start pulses every 98 cycles; underrun stays 0.
2. Drop pix_valid for the 2nd slot of line 0
   → bytes for that slot are 00,00 with de_o=1; underrun=1; the next pixel appears in slot 3.
   → Only 11 pixels are consumed in the frame.
3. Deassert enable at cycle 50 of a frame
   → the frame completes at cycle 98, then the block returns to IDLE with all outputs 0.
   → Reasserting enable gives vs_o high one cycle later, with frame_start.
4. Assert rst during the 2nd active line, between the high and low byte
   → outputs clear on the same cycle; the held low byte is never emitted; underrun clears.
   → After reset release with enable=1, a full new frame starts.
5. Loop back into the 8→16 receiver
   → every received 16-bit word equals the sent pix_data, and there are 12 words per frame.

Source files
------------

// File: rtl/cmos_16_8bit_tx_if.sv
// Pixel-in / DVP byte-out bundle for the 16->8 camera-style transmitter.
// The transmitter is the master of the byte stream; the environment is the slave.
interface cmos_16_8bit_tx_if;
    logic        enable;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        vs_o;
    logic        de_o;
    logic [7:0]  pdata_o;
    logic        frame_start;
    logic        underrun;

    modport master (
        input  enable, pix_data, pix_valid,
        output pix_ready, vs_o, de_o, pdata_o, frame_start, underrun
    );

    modport slave (
        output enable, pix_data, pix_valid,
        input  pix_ready, vs_o, de_o, pdata_o, frame_start, underrun
    );
endinterface

// File: rtl/cmos_16_8bit_tx.sv
// DVP-style transmitter: serializes RGB565 pixels into high/low bytes inside
// camera-like vsync/href frame timing; the byte slot timing never waits for data.
module cmos_16_8bit_tx #(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 144,
    parameter int V_SYNC   = 3,
    parameter int V_BACK   = 17,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10
) (
    input  logic                  pclk,
    input  logic                  rst,
    cmos_16_8bit_tx_if.master     bus
);

    typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_e;

    localparam int L     = 2 * H_ACTIVE + H_BLANK;
    localparam int HW    = (L > 1) ? $clog2(L) : 1;
    localparam int V_M1  = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
    localparam int V_M2  = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int V_MAX = (V_M1 > V_M2) ? V_M1 : V_M2;
    localparam int VW    = (V_MAX > 1) ? $clog2(V_MAX) : 1;
    localparam logic [HW-1:0] H_LAST = HW'(L - 1);

    function automatic logic has_lines(state_e s);
        case (s)
            VSYNC:   return V_SYNC   != 0;
            VBACK:   return V_BACK   != 0;
            ACTIVE:  return V_ACTIVE != 0;
            VFRONT:  return V_FRONT  != 0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [VW-1:0] last_line(state_e s);
        case (s)
            VSYNC:   return VW'(V_SYNC - 1);
            VBACK:   return VW'(V_BACK - 1);
            ACTIVE:  return VW'(V_ACTIVE - 1);
            VFRONT:  return VW'(V_FRONT - 1);
            default: return '0;
        endcase
    endfunction

    // enable is only consulted where a frame may begin: in IDLE and at frame end.
    function automatic state_e succ(state_e s, logic en);
        case (s)
            IDLE:    return en ? VSYNC : IDLE;
            VSYNC:   return VBACK;
            VBACK:   return ACTIVE;
            ACTIVE:  return VFRONT;
            default: return en ? VSYNC : IDLE;
        endcase
    endfunction

    // Zero-length states are skipped so they consume no cycles at all.
    function automatic state_e enter(state_e s, logic en);
        state_e n;
        n = succ(s, en);
        for (int i = 0; i < 4; i++) begin
            if (!has_lines(n)) n = succ(n, en);
        end
        return n;
    endfunction

    state_e          state_q, state_d;
    logic [HW-1:0]   hcnt_q, hcnt_d;
    logic [VW-1:0]   vcnt_q, vcnt_d;
    logic [7:0]      low_q, low_d;
    logic [7:0]      pdata_q, pdata_d;
    logic            vs_q, vs_d;
    logic            de_q, de_d;
    logic            frame_start_q, frame_start_d;
    logic            underrun_q, underrun_d;
    logic            in_line, slot_hi, pix_ready;

    // The counters describe the output cycle about to be registered, so every
    // output is decoded from the *_d position and appears on the next cycle.
    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latches).
    always_comb begin
        state_d       = state_q;
        hcnt_d        = hcnt_q;
        vcnt_d        = vcnt_q;
        low_d         = low_q;
        underrun_d    = underrun_q;
        pdata_d       = 8'h00;

        if (state_q == IDLE) begin
            if (bus.enable) begin
                state_d = enter(IDLE, 1'b1);
                hcnt_d  = '0;
                vcnt_d  = '0;
            end
        end else if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            if (vcnt_q == last_line(state_q)) begin
                vcnt_d  = '0;
                state_d = enter(state_q, bus.enable);
            end else begin
                vcnt_d = vcnt_q + VW'(1);
            end
        end else begin
            hcnt_d = hcnt_q + HW'(1);
        end

        in_line       = (state_d == ACTIVE) && (int'(hcnt_d) < 2 * H_ACTIVE);
        slot_hi       = in_line && !hcnt_d[0];
        pix_ready     = slot_hi && !rst;
        vs_d          = (state_d == VSYNC);
        de_d          = in_line;
        frame_start_d = vs_d && (hcnt_d == '0) && (vcnt_d == '0);

        // A missing pixel still burns its slot: zero bytes go out and the flag sticks.
        if (slot_hi) begin
            if (bus.pix_valid) begin
                pdata_d = bus.pix_data[15:8];
                low_d   = bus.pix_data[7:0];
            end else begin
                low_d      = 8'h00;
                underrun_d = 1'b1;
            end
        end else if (in_line) begin
            pdata_d = low_q;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            low_q         <= 8'h00;
            pdata_q       <= 8'h00;
            vs_q          <= 1'b0;
            de_q          <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            low_q         <= low_d;
            pdata_q       <= pdata_d;
            vs_q          <= vs_d;
            de_q          <= de_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
        end
    end

    assign bus.pix_ready   = pix_ready;
    assign bus.vs_o        = vs_q;
    assign bus.de_o        = de_q;
    assign bus.pdata_o     = pdata_q;
    assign bus.frame_start = frame_start_q;
    assign bus.underrun    = underrun_q;

endmodule
